// File: rtl/l2_pkg.sv
// Shared L2 port definitions: line geometry used by the L1 caches, the L2 and the
// port arbiter, plus the arbiter state encoding.
package l2_pkg;

    localparam int L2_ADDR_W = 28;
    localparam int L2_DATA_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } state_t;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/l2_watchdog.sv
// Transaction watchdog: counts cycles a port stays busy without completing and
// raises a sticky error once the count reaches TIMEOUT.
module l2_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic done,
    output logic err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        if (!active || done) begin
            cnt_next = '0;
        end else if (wait_cnt == LIMIT) begin
            cnt_next = wait_cnt;
        end else begin
            cnt_next = wait_cnt + 1'b1;
        end
    end

    // Error flag and count update on the same edge, so err is visible exactly
    // when the count first reads TIMEOUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= cnt_next;
            if (cnt_next == LIMIT) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between the I-cache miss
// path and the D-cache miss/write-back path, with a transaction watchdog.
module l2_port_arbiter
    import l2_pkg::*;
#(
    parameter int ADDR_W  = L2_ADDR_W,
    parameter int DATA_W  = L2_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              timeout_err
);

    state_t state, state_next;
    logic   last_gnt, last_gnt_next;
    logic   i_req, d_req;
    logic   owner_active;

    assign i_req   = i_read;
    assign d_req   = d_read | d_write;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    // NOTE: every output of this block gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_next    = state;
        last_gnt_next = last_gnt;
        owner_active  = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        i_ready       = 1'b0;
        d_ready       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    state_next = (last_gnt == LAST_D) ? ST_GNT_I : ST_GNT_D;
                end else if (i_req) begin
                    state_next = ST_GNT_I;
                end else if (d_req) begin
                    state_next = ST_GNT_D;
                end
            end
            ST_GNT_I: begin
                if (!i_req) begin
                    state_next = ST_IDLE;
                end else begin
                    owner_active = 1'b1;
                    mem_read     = 1'b1;
                    mem_addr     = i_addr;
                    i_ready      = mem_ready;
                    if (mem_ready) begin
                        state_next    = ST_IDLE;
                        last_gnt_next = LAST_I;
                    end
                end
            end
            ST_GNT_D: begin
                if (!d_req) begin
                    state_next = ST_IDLE;
                end else begin
                    // A write-back takes precedence over a simultaneous read.
                    owner_active = 1'b1;
                    mem_write    = d_write;
                    mem_read     = d_read & ~d_write;
                    mem_addr     = d_addr;
                    mem_wdata    = d_wdata;
                    d_ready      = mem_ready;
                    if (mem_ready) begin
                        state_next    = ST_IDLE;
                        last_gnt_next = LAST_D;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; the asynchronous reset returns the port to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_gnt <= LAST_I;
        end else begin
            state    <= state_next;
            last_gnt <= last_gnt_next;
        end
    end

    l2_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (owner_active),
        .done   (mem_ready),
        .err    (timeout_err)
    );

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: directed scenarios plus randomized
// cache traffic compared cycle by cycle against a transaction-level model.
module tb_l2_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int TO = 1023;
    localparam int OW = 5 + AW + 3 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          i_ready, d_ready, mem_read, mem_write, timeout_err;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the port (0 none, 1 I-cache, 2 D-cache), who was
    // served last, and how long the current owner has waited.
    int m_owner;
    int m_last_served;
    int m_wait;
    bit m_err;

    // Values sampled in the most recent cycle, for the scenario tasks.
    logic          s_mem_read, s_mem_write, s_i_ready, s_d_ready, s_err;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_d_rdata;

    task automatic model_reset();
        m_owner       = 0;
        m_last_served = 1;   // makes D win the first tie
        m_wait        = 0;
        m_err         = 1'b0;
    endtask

    // Called at posedge+1: drives inputs, compares at negedge, returns at posedge+1.
    task automatic apply_cycle(input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic dw,
                               input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                               input logic mr, input logic [DW-1:0] mrd);
        logic          busy;
        logic          e_rd, e_wr, e_ir, e_dr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [OW-1:0] obs, exp;
        i_read = ir; i_addr = ia; d_read = dr; d_write = dw;
        d_addr = da; d_wdata = dwd; mem_ready = mr; mem_rdata = mrd;
        @(negedge clk);
        e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
        e_addr = '0; e_wdata = '0; busy = 1'b0;
        if (m_owner == 1 && ir) begin
            busy = 1'b1; e_rd = 1'b1; e_addr = ia; e_ir = mr;
        end else if (m_owner == 2 && (dr || dw)) begin
            busy = 1'b1; e_wr = dw; e_rd = dr && !dw; e_addr = da; e_wdata = dwd; e_dr = mr;
        end
        exp = {e_rd, e_wr, e_ir, e_dr, m_err, e_addr, e_wdata, mrd, mrd};
        obs = {mem_read, mem_write, i_ready, d_ready, timeout_err, mem_addr, mem_wdata, i_rdata, d_rdata};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, obs, exp);
        end
        s_mem_read = mem_read; s_mem_write = mem_write; s_i_ready = i_ready;
        s_d_ready = d_ready; s_err = timeout_err; s_addr = mem_addr;
        s_wdata = mem_wdata; s_d_rdata = d_rdata;
        if (busy && !mr) begin
            m_wait = (m_wait < TO) ? m_wait + 1 : TO;
            if (m_wait == TO) m_err = 1'b1;
        end else begin
            m_wait = 0;
        end
        if (m_owner == 0) begin
            if (ir && (dr || dw)) m_owner = (m_last_served == 2) ? 1 : 2;
            else if (ir)          m_owner = 1;
            else if (dr || dw)    m_owner = 2;
        end else if (!busy) begin
            m_owner = 0;
        end else if (mr) begin
            m_last_served = m_owner;
            m_owner       = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = 1; d_write = 1; d_read = 0; mem_ready = 1;
        i_addr = 28'h123; d_addr = 28'h456; d_wdata = '1; mem_rdata = '0;
        #3;
        n_vec++;
        if ({mem_read, mem_write, i_ready, d_ready, timeout_err} !== 5'b0 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %b/%h expected 00000/0",
                     {mem_read, mem_write, i_ready, d_ready, timeout_err}, mem_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        i_read = 0; d_write = 0; mem_ready = 0;
    endtask

    task automatic test_single_d();
        logic [DW-1:0] line = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;
        do_reset();
        apply_cycle(0, '0, 1, 0, 28'h0000040, '0, 0, '0);
        apply_cycle(0, '0, 1, 0, 28'h0000040, '0, 0, '0);
        n_vec++;
        if (s_mem_read !== 1'b1 || s_addr !== 28'h0000040) begin
            n_err++;
            $display("FAIL single_d_grant got rd=%b addr=%h expected rd=1 addr=0000040", s_mem_read, s_addr);
        end
        repeat (2) apply_cycle(0, '0, 1, 0, 28'h0000040, '0, 0, '0);
        apply_cycle(0, '0, 1, 0, 28'h0000040, '0, 1, line);
        n_vec++;
        if (s_d_ready !== 1'b1 || s_d_rdata !== line || s_i_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_d_ready got rdy=%b data=%h expected rdy=1 data=%h", s_d_ready, s_d_rdata, line);
        end
        apply_cycle(0, '0, 0, 0, '0, '0, 1, line);
        n_vec++;
        if (s_d_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_d_pulse got d_ready=%b expected 0", s_d_ready);
        end
    endtask

    task automatic test_tie_after_reset();
        logic [DW-1:0] wd = 128'hA5A5_0001_0002_0003_0004_0005_0006_0007;
        do_reset();
        apply_cycle(1, 28'h0ABCDE0, 0, 1, 28'h0000100, wd, 0, '0);
        apply_cycle(1, 28'h0ABCDE0, 0, 1, 28'h0000100, wd, 1, '0);
        n_vec++;
        if (s_mem_write !== 1'b1 || s_wdata !== wd || s_d_ready !== 1'b1) begin
            n_err++;
            $display("FAIL tie_d_first got wr=%b wdata=%h rdy=%b expected wr=1 wdata=%h rdy=1",
                     s_mem_write, s_wdata, s_d_ready, wd);
        end
        apply_cycle(1, 28'h0ABCDE0, 0, 0, '0, '0, 0, '0);
        n_vec++;
        if (s_mem_read !== 1'b0 || s_mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL idle_bubble got rd=%b wr=%b expected 0 0", s_mem_read, s_mem_write);
        end
        apply_cycle(1, 28'h0ABCDE0, 0, 0, '0, '0, 1, '0);
        n_vec++;
        if (s_mem_read !== 1'b1 || s_addr !== 28'h0ABCDE0 || s_i_ready !== 1'b1) begin
            n_err++;
            $display("FAIL tie_i_second got rd=%b addr=%h rdy=%b expected 1 0abcde0 1", s_mem_read, s_addr, s_i_ready);
        end
        apply_cycle(0, '0, 1, 1, 28'h0000200, wd, 0, '0);
        apply_cycle(0, '0, 1, 1, 28'h0000200, wd, 0, '0);
        n_vec++;
        if (s_mem_write !== 1'b1 || s_mem_read !== 1'b0) begin
            n_err++;
            $display("FAIL read_write_both got rd=%b wr=%b expected rd=0 wr=1", s_mem_read, s_mem_write);
        end
        apply_cycle(0, '0, 1, 1, 28'h0000200, wd, 1, '0);
    endtask

    task automatic test_round_robin();
        int            order[$];
        int            budget = 300;
        logic [AW-1:0] ia = 28'h1000, da = 28'h2000;
        do_reset();
        while (order.size() < 6 && budget > 0) begin
            apply_cycle(1, ia, 1, 0, da, '0, ($urandom_range(0, 2) == 0), {4{$urandom}});
            budget--;
            n_vec++;
            if (s_i_ready && s_d_ready) begin
                n_err++;
                $display("FAIL rr_both_ready got i=1 d=1 expected at most one");
            end
            if (s_d_ready) begin order.push_back(2); da = da + 28'h40; end
            if (s_i_ready) begin order.push_back(1); ia = ia + 28'h40; end
        end
        n_vec++;
        if (order.size() < 6) begin
            n_err++;
            $display("FAIL rr_budget got %0d transactions expected 6", order.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_vec++;
                if (order[k] !== ((k % 2 == 0) ? 2 : 1)) begin
                    n_err++;
                    $display("FAIL rr_order[%0d] got %0d expected %0d", k, order[k], (k % 2 == 0) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        apply_cycle(1, 28'h0000300, 0, 0, '0, '0, 0, '0);
        apply_cycle(1, 28'h0000300, 0, 0, '0, '0, 0, '0);
        apply_cycle(0, 28'h0000300, 0, 0, '0, '0, 0, '0);
        n_vec++;
        if (s_mem_read !== 1'b0 || s_addr !== '0) begin
            n_err++;
            $display("FAIL drop_deassert got rd=%b addr=%h expected 0 0", s_mem_read, s_addr);
        end
        // The dropped I grant must not count as served: D still wins the tie.
        apply_cycle(1, 28'h0000300, 0, 1, 28'h0000400, '1, 0, '0);
        apply_cycle(1, 28'h0000300, 0, 1, 28'h0000400, '1, 1, '0);
        n_vec++;
        if (s_mem_write !== 1'b1 || s_mem_read !== 1'b0) begin
            n_err++;
            $display("FAIL drop_last_gnt got rd=%b wr=%b expected rd=0 wr=1", s_mem_read, s_mem_write);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        apply_cycle(0, '0, 1, 0, 28'h0000500, '0, 0, '0);
        for (int k = 1; k <= TO + 1; k++) begin
            apply_cycle(0, '0, 1, 0, 28'h0000500, '0, 0, '0);
            if (k == TO) begin
                n_vec++;
                if (s_err !== 1'b0) begin
                    n_err++;
                    $display("FAIL timeout_early got %b expected 0", s_err);
                end
            end
        end
        n_vec++;
        if (s_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_set got %b expected 1", s_err);
        end
        apply_cycle(0, '0, 1, 0, 28'h0000500, '0, 1, '0);
        repeat (3) apply_cycle(0, '0, 0, 0, '0, '0, 0, '0);
        n_vec++;
        if (s_err !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky got %b expected 1", s_err);
        end
        apply_cycle(0, '0, 1, 0, 28'h0000600, '0, 0, '0);
        apply_cycle(0, '0, 1, 0, 28'h0000600, '0, 0, '0);
        mem_ready = 1'b1;
        #2;
        n_vec++;
        if (d_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_ready got %b expected 1", d_ready);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({mem_read, mem_write, i_ready, d_ready, timeout_err} !== 5'b0 || mem_addr !== '0) begin
            n_err++;
            $display("FAIL mid_grant_reset got %b/%h expected 00000/0",
                     {mem_read, mem_write, i_ready, d_ready, timeout_err}, mem_addr);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic          ir = 0, dr = 0, dw = 0, drop;
        logic [AW-1:0] ia = '0, da = '0;
        logic [DW-1:0] dwd = '0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            drop = 1'b0;
            if (!ir && $urandom_range(0, 3) == 0) begin ir = 1; ia = AW'($urandom); end
            if (!dr && !dw && $urandom_range(0, 3) == 0) begin
                dr = $urandom_range(0, 1); dw = !dr || ($urandom_range(0, 3) == 0);
                da = AW'($urandom); dwd = {4{$urandom}};
            end
            if (ir && $urandom_range(0, 40) == 0) begin ir = 0; drop = 1; end
            if ((dr || dw) && $urandom_range(0, 40) == 0) begin dr = 0; dw = 0; drop = 1; end
            apply_cycle(ir, ia, dr, dw, da, dwd, !drop && ($urandom_range(0, 2) == 0), {4{$urandom}});
            if (s_i_ready) begin ir = $urandom_range(0, 1); ia = AW'($urandom); end
            if (s_d_ready) begin dr = 0; dw = 0; end
        end
    endtask

    initial begin
        test_reset();
        test_single_d();
        test_tie_after_reset();
        test_round_robin();
        test_drop();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
